// File: rtl/piso_tx_scheduler_if.sv
// Bundle between the parallel producers and the serializer: requests, words,
// grants and the serial-line qualifiers.
interface piso_tx_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       gnt;
    logic                  Q;
    logic                  frame;
    logic [ID_W-1:0]       src_id;
    logic                  busy;
    logic                  done;

    modport master (
        output req, data_in,
        input  gnt, Q, frame, src_id, busy, done
    );

    modport slave (
        input  req, data_in,
        output gnt, Q, frame, src_id, busy, done
    );
endinterface

// File: rtl/piso_tx_scheduler.sv
// Round-robin arbiter feeding one shared PISO shift register; words leave MSB
// first with a frame qualifier and an optional idle gap between words.
module piso_tx_scheduler #(
    parameter int WIDTH      = 8,
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    piso_tx_scheduler_if.slave bus
);
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [3:0]       gap_cnt_reg;
    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  src_id_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic             q_reg;
    logic             frame_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] words [NREQ];
    logic [NREQ-1:0]  req_rot;
    logic [ID_W:0]    win_sum;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  ptr_next;
    logic             found;
    logic             last_bit;
    logic             load;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
            assign words[gi] = bus.data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate requests so bit 0 is the current priority holder.
    assign req_rot = NREQ'({bus.req, bus.req} >> ptr_reg);
    assign found   = |bus.req;

    always_comb begin
        win_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
            end
        end
        if (win_sum >= (ID_W+1)'(NREQ)) begin
            winner = ID_W'(win_sum - (ID_W+1)'(NREQ));
        end else begin
            winner = win_sum[ID_W-1:0];
        end
        ptr_next = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

    assign last_bit = (bit_cnt_reg == CNT_W'(WIDTH - 1));
    // With no gap, the edge ending a word may immediately start the next one.
    assign load = found && ((state_reg == IDLE) ||
                            ((state_reg == SHIFT) && last_bit && (GAP_CYCLES == 0)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            ptr_reg     <= '0;
            src_id_reg  <= '0;
            gnt_reg     <= '0;
            q_reg       <= 1'b0;
            frame_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            gnt_reg  <= '0;
            done_reg <= 1'b0;
            if (load) begin
                state_reg   <= SHIFT;
                shift_reg   <= words[winner];
                q_reg       <= words[winner][WIDTH-1];
                bit_cnt_reg <= '0;
                src_id_reg  <= winner;
                gnt_reg     <= NREQ'(1) << winner;
                ptr_reg     <= ptr_next;
                frame_reg   <= 1'b1;
                busy_reg    <= 1'b1;
                done_reg    <= (state_reg == SHIFT);
            end else begin
                case (state_reg)
                    IDLE: begin
                        busy_reg <= 1'b0;
                    end
                    SHIFT: begin
                        if (last_bit) begin
                            done_reg  <= 1'b1;
                            q_reg     <= 1'b0;
                            frame_reg <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state_reg   <= GAP;
                                gap_cnt_reg <= '0;
                                busy_reg    <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            shift_reg   <= shift_reg << 1;
                            q_reg       <= shift_reg[WIDTH-2];
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_cnt_reg == 4'(GAP_CYCLES - 1)) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 4'd1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.Q      = q_reg;
    assign bus.frame  = frame_reg;
    assign bus.src_id = src_id_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Two schedulers (gap of 1 and gap of 0) checked each cycle against a queue of
// expected output cycles built from the word/gap/idle timing rules.
module tb_piso_tx_scheduler;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int RING  = 32;

    typedef struct packed {
        logic            q;
        logic            frame;
        logic            busy;
        logic            done;
        logic [NREQ-1:0] gnt;
        logic [ID_W-1:0] src;
        logic            last;
    } cyc_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piso_tx_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus_a ();
    piso_tx_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus_b ();

    piso_tx_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP_CYCLES(1)) dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_a)
    );

    piso_tx_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_b)
    );

    int              gap_len [2];
    cyc_t            ring [2][RING];
    int              head [2];
    int              cnt [2];
    int              ptr [2];
    int              last_src [2];
    logic            done_next [2];
    logic [NREQ-1:0] req_v [2];
    logic [WIDTH-1:0] word_v [2][NREQ];
    logic [NREQ-1:0] gnt_seen [2];
    int              glog [2][64];
    int              gcount [2];
    logic [WIDTH-1:0] cap [2];
    int              run_len [2];
    int              max_run [2];
    bit              auto_mode;
    bit              drop_on_grant;
    int              checks;
    int              failures;

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, got, exp);
        end
    endtask

    function automatic cyc_t get_obs(input int d);
        cyc_t o;
        o = '0;
        if (d == 0) begin
            o.q = bus_a.Q; o.frame = bus_a.frame; o.busy = bus_a.busy;
            o.done = bus_a.done; o.gnt = bus_a.gnt; o.src = bus_a.src_id;
        end else begin
            o.q = bus_b.Q; o.frame = bus_b.frame; o.busy = bus_b.busy;
            o.done = bus_b.done; o.gnt = bus_b.gnt; o.src = bus_b.src_id;
        end
        return o;
    endfunction

    task automatic check_zero(input string tag);
        cyc_t o;
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            chk({tag, "_q"}, d, 32'(o.q), 32'd0);
            chk({tag, "_frame"}, d, 32'(o.frame), 32'd0);
            chk({tag, "_busy"}, d, 32'(o.busy), 32'd0);
            chk({tag, "_done"}, d, 32'(o.done), 32'd0);
            chk({tag, "_gnt"}, d, 32'(o.gnt), 32'd0);
            chk({tag, "_src"}, d, 32'(o.src), 32'd0);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            head[d] = 0; cnt[d] = 0; ptr[d] = 0; last_src[d] = 0;
            done_next[d] = 1'b0; req_v[d] = '0; gnt_seen[d] = '0; run_len[d] = 0;
        end
    endtask

    task automatic push(input int d, input cyc_t e);
        ring[d][(head[d] + cnt[d]) % RING] = e;
        cnt[d]++;
    endtask

    task automatic check_cycle(input int d);
        cyc_t o;
        cyc_t e;
        int   idx;
        o = get_obs(d);
        if (cnt[d] > 0) begin
            e = ring[d][head[d]];
        end else begin
            e = '0;
            e.done = done_next[d];
            e.src = ID_W'(last_src[d]);
        end
        chk("q", d, 32'(o.q), 32'(e.q));
        chk("frame", d, 32'(o.frame), 32'(e.frame));
        chk("busy", d, 32'(o.busy), 32'(e.busy));
        chk("done", d, 32'(o.done), 32'(e.done));
        chk("gnt", d, 32'(o.gnt), 32'(e.gnt));
        chk("src_id", d, 32'(o.src), 32'(e.src));
        gnt_seen[d] = o.gnt;
        if (o.gnt != '0) begin
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (o.gnt[i]) idx = i;
            glog[d][gcount[d] % 64] = idx;
            gcount[d]++;
            $display("dut%0d t=%0t grant requester=%0d src_id=%0d", d, $time, idx, o.src);
        end
        if (o.frame === 1'b1) begin
            cap[d] = {cap[d][WIDTH-2:0], o.q};
            run_len[d]++;
            if (run_len[d] > max_run[d]) max_run[d] = run_len[d];
        end else begin
            run_len[d] = 0;
        end
    endtask

    task automatic drive(input int d);
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_seen[d][i]) begin
                if (auto_mode) begin
                    if ($urandom_range(1, 0) == 0) req_v[d][i] = 1'b0;
                    else word_v[d][i] = WIDTH'($urandom);
                end else if (drop_on_grant) begin
                    req_v[d][i] = 1'b0;
                end
            end else if (auto_mode) begin
                if (req_v[d][i]) begin
                    if ($urandom_range(15, 0) == 0) req_v[d][i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    req_v[d][i] = 1'b1;
                    word_v[d][i] = WIDTH'($urandom);
                end
            end
        end
    endtask

    task automatic apply();
        bus_a.req = req_v[0];
        bus_b.req = req_v[1];
        for (int i = 0; i < NREQ; i++) begin
            bus_a.data_in[i*WIDTH +: WIDTH] = word_v[0][i];
            bus_b.data_in[i*WIDTH +: WIDTH] = word_v[1][i];
        end
    endtask

    // Expected future: a granted word is WIDTH framed bits, then gap cycles,
    // then (when a gap exists) one idle cycle before arbitration resumes.
    task automatic model_edge(input int d);
        cyc_t e;
        logic dn;
        int   w;
        dn = 1'b0;
        if (cnt[d] > 0) begin
            e = ring[d][head[d]];
            head[d] = (head[d] + 1) % RING;
            cnt[d]--;
            if (e.last && gap_len[d] == 0) dn = 1'b1;
        end
        done_next[d] = 1'b0;
        if (cnt[d] == 0) begin
            w = -1;
            for (int s = 0; s < NREQ; s++) begin
                if (w < 0 && req_v[d][(ptr[d] + s) % NREQ]) w = (ptr[d] + s) % NREQ;
            end
            if (w >= 0) begin
                for (int b = 0; b < WIDTH; b++) begin
                    e = '0;
                    e.q = word_v[d][w][WIDTH-1-b];
                    e.frame = 1'b1;
                    e.busy = 1'b1;
                    e.src = ID_W'(w);
                    e.done = (b == 0) ? dn : 1'b0;
                    e.gnt = (b == 0) ? (NREQ'(1) << w) : '0;
                    e.last = (b == WIDTH - 1);
                    push(d, e);
                end
                for (int g = 0; g < gap_len[d]; g++) begin
                    e = '0; e.busy = 1'b1; e.done = (g == 0); e.src = ID_W'(w);
                    push(d, e);
                end
                if (gap_len[d] > 0) begin
                    e = '0; e.src = ID_W'(w);
                    push(d, e);
                end
                ptr[d] = (w + 1) % NREQ;
                last_src[d] = w;
            end else begin
                done_next[d] = dn;
            end
        end
    endtask

    task automatic cycle();
        for (int d = 0; d < 2; d++) check_cycle(d);
        for (int d = 0; d < 2; d++) drive(d);
        apply();
        for (int d = 0; d < 2; d++) model_edge(d);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [NREQ-1:0] r);
        req_v[0] = r;
        req_v[1] = r;
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] w);
        word_v[0][i] = w;
        word_v[1][i] = w;
    endtask

    initial begin
        checks = 0; failures = 0;
        auto_mode = 1'b0; drop_on_grant = 1'b1;
        gap_len[0] = 1; gap_len[1] = 0;
        for (int d = 0; d < 2; d++) begin
            gcount[d] = 0; cap[d] = '0; max_run[d] = 0;
            for (int i = 0; i < NREQ; i++) word_v[d][i] = '0;
        end
        reset_model();
        apply();
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;
        repeat (3) cycle();

        // Single word from requester 2.
        set_word(2, 8'hA5);
        set_req(4'b0100);
        for (int d = 0; d < 2; d++) begin gcount[d] = 0; cap[d] = '0; end
        repeat (14) cycle();
        for (int d = 0; d < 2; d++) begin
            chk("single_word_bits", d, 32'(cap[d]), 32'h0000_00A5);
            chk("single_word_grants", d, 32'(gcount[d]), 32'd1);
            chk("single_word_winner", d, 32'(glog[d][0]), 32'd2);
        end

        // Asynchronous reset in the middle of a word.
        set_word(0, 8'h3C);
        set_req(4'b0001);
        repeat (4) cycle();
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        reset_model();
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();

        // Round-robin with all requesters held.
        set_word(0, 8'h11); set_word(1, 8'h22); set_word(2, 8'h33); set_word(3, 8'h44);
        drop_on_grant = 1'b0;
        for (int d = 0; d < 2; d++) gcount[d] = 0;
        set_req(4'b1111);
        repeat (45) cycle();
        set_req(4'b0000);
        repeat (12) cycle();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 5; k++) chk("rr_order", d, 32'(glog[d][k]), 32'(k % NREQ));
        end

        // Two requesters: back-to-back without a gap, separated with one.
        drop_on_grant = 1'b1;
        set_word(0, 8'hC3); set_word(1, 8'h96);
        for (int d = 0; d < 2; d++) max_run[d] = 0;
        set_req(4'b0011);
        repeat (24) cycle();
        chk("gap_run", 0, 32'(max_run[0]), 32'd8);
        chk("b2b_run", 1, 32'(max_run[1]), 32'd16);

        // One-cycle pulse on req[3] while requester 0 shifts.
        for (int d = 0; d < 2; d++) gcount[d] = 0;
        set_req(4'b0001);
        repeat (4) cycle();
        req_v[0][3] = 1'b1; req_v[1][3] = 1'b1;
        cycle();
        req_v[0][3] = 1'b0; req_v[1][3] = 1'b0;
        repeat (14) cycle();
        for (int d = 0; d < 2; d++) begin
            chk("withdraw_grants", d, 32'(gcount[d]), 32'd1);
            chk("withdraw_winner", d, 32'(glog[d][0]), 32'd0);
        end

        // Requester 1 drops its request mid-word.
        set_word(1, 8'h5A);
        drop_on_grant = 1'b0;
        for (int d = 0; d < 2; d++) cap[d] = '0;
        set_req(4'b0010);
        repeat (4) cycle();
        req_v[0][1] = 1'b0; req_v[1][1] = 1'b0;
        repeat (12) cycle();
        for (int d = 0; d < 2; d++) chk("drop_mid_word", d, 32'(cap[d]), 32'h0000_005A);

        // Pointer wraps after requester 3.
        drop_on_grant = 1'b1;
        set_req(4'b1000);
        repeat (12) cycle();
        for (int d = 0; d < 2; d++) gcount[d] = 0;
        set_req(4'b1001);
        repeat (24) cycle();
        for (int d = 0; d < 2; d++) begin
            chk("wrap_first", d, 32'(glog[d][0]), 32'd0);
            chk("wrap_second", d, 32'(glog[d][1]), 32'd3);
        end

        // Random requesters.
        auto_mode = 1'b1;
        repeat (1500) cycle();
        auto_mode = 1'b0;
        set_req(4'b0000);
        repeat (15) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
